// File: rtl/riscv_trace_buffer_pkg.sv
// Shared debug definitions for the commit-trace buffer: FSM state codes,
// trigger mode codes and the width of one stored trace entry.
package riscv_dbg_pkg;

  // Capture FSM state encoding, also visible on the state output
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Trigger condition encoding on trig_mode
  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_PC        = 2'd1;
  localparam logic [1:0] TRIG_DATA      = 2'd2;
  localparam logic [1:0] TRIG_NEVER     = 2'd3;

  // One entry holds the 32-bit PC followed by the result word
  function automatic int entry_width(input int data_width);
    return 32 + data_width;
  endfunction

endpackage

// File: rtl/riscv_trace_buffer_if.sv
// Bundle of capture, trigger and readout signals of the trace buffer.
// The core/debug side uses the master view, the buffer uses the slave view.
interface riscv_trace_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  import riscv_dbg_pkg::*;

  localparam int EW = entry_width(DATA_WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  cap_valid;
  logic [31:0]           cap_pc;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  arm;
  logic [1:0]            trig_mode;
  logic [31:0]           trig_value;
  logic                  rd_en;
  logic [EW-1:0]         rd_data;
  logic                  rd_valid;
  logic [CW-1:0]         count;
  logic [1:0]            state;
  logic                  triggered;

  modport master (
    output cap_valid, cap_pc, cap_data, arm, trig_mode, trig_value, rd_en,
    input  rd_data, rd_valid, count, state, triggered
  );

  modport slave (
    input  cap_valid, cap_pc, cap_data, arm, trig_mode, trig_value, rd_en,
    output rd_data, rd_valid, count, state, triggered
  );

endinterface

// File: rtl/riscv_trace_buffer_ram.sv
// Trace storage: DEPTH x WIDTH array with synchronous write and registered
// read. No reset, so it maps onto plain RAM; the read register holds its
// value whenever no read is requested.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store a new entry at the write pointer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read, holding the last value between reads
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture buffer. Retired instructions are written into a
// circular buffer while armed; a selectable trigger starts a post-trigger
// countdown, after which the buffer freezes and is read oldest-first.
module riscv_trace_buffer
  import riscv_dbg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 8
) (
  input logic                CLK,
  input logic                RST,
  riscv_trace_buffer_if.slave bus
);

  localparam int EW = entry_width(DATA_WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] POST_CNT = CW'(POST_TRIG);

  logic [1:0]    state_q,     state_d;
  logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0] count_q,     count_d;
  logic [CW-1:0] post_q,      post_d;
  logic          triggered_q, triggered_d;
  logic          rd_valid_q;
  logic          have_read_q;
  logic          trig_hit;
  logic          wr_en;
  logic          rd_accept;
  logic [EW-1:0] ram_q;

  // Trigger condition evaluated on the entry presented this cycle
  always_comb begin
    trig_hit = 1'b0;
    case (bus.trig_mode)
      TRIG_IMMEDIATE: trig_hit = 1'b1;
      TRIG_PC:        trig_hit = (bus.cap_pc == bus.trig_value);
      TRIG_DATA:      trig_hit = (bus.cap_data == DATA_WIDTH'(bus.trig_value));
      TRIG_NEVER:     trig_hit = 1'b0;
      default:        trig_hit = 1'b0;
    endcase
  end

  // Next-state logic: arm wins over everything, then capture or readout
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    post_d      = post_q;
    triggered_d = triggered_q;
    wr_en       = 1'b0;
    rd_accept   = 1'b0;
    if (bus.arm) begin
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      count_d     = '0;
      post_d      = '0;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          if (bus.cap_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q != FULL) begin
              count_d = count_q + CW'(1);
            end
            if (state_q == ST_ARMED) begin
              if (trig_hit) begin
                triggered_d = 1'b1;
                post_d      = POST_CNT;
                state_d     = (POST_TRIG == 0) ? ST_DONE : ST_POST;
              end
            end else begin
              post_d = post_q - CW'(1);
              if (post_q == CW'(1)) begin
                state_d = ST_DONE;
              end
            end
            // A full buffer wraps to rd_ptr == wr_ptr, the oldest slot
            if (state_d == ST_DONE) begin
              rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
            end
          end
        end
        ST_DONE: begin
          if (bus.rd_en && (count_q != '0)) begin
            rd_accept = 1'b1;
            rd_ptr_d  = rd_ptr_q + AW'(1);
            count_d   = count_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Register FSM, pointers and flags; reset aborts any capture or readout
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_q      <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      have_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      post_q      <= post_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_accept;
      have_read_q <= have_read_q | rd_accept;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (CLK),
    .wr_en   (wr_en & RST),
    .wr_addr (wr_ptr_q),
    .wr_data ({bus.cap_pc, bus.cap_data}),
    .rd_en   (rd_accept & RST),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_q)
  );

  // The RAM read register is not reset, so rd_data reads zero until the
  // first accepted read after reset
  assign bus.rd_data   = have_read_q ? ram_q : '0;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.count     = count_q;
  assign bus.state     = state_q;
  assign bus.triggered = triggered_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Testbench for riscv_trace_buffer: two instances (8 and 0 post-trigger
// entries) share one stimulus stream and are compared every cycle against
// a history-based reference model, plus targeted scenario checks.
module tb_riscv_trace_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int HIST  = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, cap_valid, rd_en;
  logic [31:0] cap_pc, cap_data, trig_value;
  logic [1:0]  trig_mode;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: full capture history since arm, per instance
  logic [63:0] m_hist [2][HIST];
  int          m_len    [2];
  int          m_phase  [2];
  int          m_left   [2];
  int          m_rd_idx [2];
  int          m_rem    [2];
  bit          m_trig   [2];
  bit          m_valid  [2];
  logic [63:0] m_data   [2];

  always #5 clk = ~clk;

  riscv_trace_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus8 ();
  riscv_trace_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();

  assign bus8.arm = arm;             assign bus0.arm = arm;
  assign bus8.cap_valid = cap_valid; assign bus0.cap_valid = cap_valid;
  assign bus8.cap_pc = cap_pc;       assign bus0.cap_pc = cap_pc;
  assign bus8.cap_data = cap_data;   assign bus0.cap_data = cap_data;
  assign bus8.trig_mode = trig_mode; assign bus0.trig_mode = trig_mode;
  assign bus8.trig_value = trig_value; assign bus0.trig_value = trig_value;
  assign bus8.rd_en = rd_en;         assign bus0.rd_en = rd_en;

  riscv_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .POST_TRIG(8)) dut8 (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus8)
  );

  riscv_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus0)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int post_of(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  // Advance the model of instance k by one clock using the current inputs
  task automatic model_step(input int k);
    bit hit;
    int n;
    m_valid[k] = 1'b0;
    if (!rst_n) begin
      m_phase[k] = 0; m_len[k] = 0; m_rem[k] = 0; m_trig[k] = 1'b0; m_data[k] = '0;
    end else if (arm) begin
      m_phase[k] = 1; m_len[k] = 0; m_trig[k] = 1'b0;
    end else if ((m_phase[k] == 1 || m_phase[k] == 2) && cap_valid) begin
      m_hist[k][m_len[k] % HIST] = {cap_pc, cap_data};
      m_len[k]++;
      case (trig_mode)
        2'd0:    hit = 1'b1;
        2'd1:    hit = (cap_pc == trig_value);
        2'd2:    hit = (cap_data == trig_value);
        default: hit = 1'b0;
      endcase
      if (m_phase[k] == 1) begin
        if (hit) begin
          m_trig[k]  = 1'b1;
          m_left[k]  = post_of(k);
          m_phase[k] = (m_left[k] == 0) ? 3 : 2;
        end
      end else begin
        m_left[k]--;
        if (m_left[k] == 0) m_phase[k] = 3;
      end
      if (m_phase[k] == 3) begin
        n = (m_len[k] < DEPTH) ? m_len[k] : DEPTH;
        m_rd_idx[k] = m_len[k] - n;
        m_rem[k]    = n;
      end
    end else if (m_phase[k] == 3 && rd_en && m_rem[k] > 0) begin
      m_data[k]  = m_hist[k][m_rd_idx[k] % HIST];
      m_valid[k] = 1'b1;
      m_rd_idx[k]++;
      m_rem[k]--;
    end
  endtask

  function automatic int exp_count(input int k);
    if (m_phase[k] == 3) return m_rem[k];
    if (m_phase[k] == 0) return 0;
    return (m_len[k] < DEPTH) ? m_len[k] : DEPTH;
  endfunction

  task automatic check_all();
    checkOutput("dut8.state",     64'(bus8.state),     64'(m_phase[0]));
    checkOutput("dut8.count",     64'(bus8.count),     64'(exp_count(0)));
    checkOutput("dut8.triggered", 64'(bus8.triggered), 64'(m_trig[0]));
    checkOutput("dut8.rd_valid",  64'(bus8.rd_valid),  64'(m_valid[0]));
    checkOutput("dut8.rd_data",   bus8.rd_data,        m_data[0]);
    checkOutput("dut0.state",     64'(bus0.state),     64'(m_phase[1]));
    checkOutput("dut0.count",     64'(bus0.count),     64'(exp_count(1)));
    checkOutput("dut0.triggered", 64'(bus0.triggered), 64'(m_trig[1]));
    checkOutput("dut0.rd_valid",  64'(bus0.rd_valid),  64'(m_valid[1]));
    checkOutput("dut0.rd_data",   bus0.rd_data,        m_data[1]);
  endtask

  // Drive one cycle of inputs, clock it, then compare after the edge
  task automatic applyStimulus(input bit a, input bit v, input logic [31:0] pc,
                               input logic [31:0] d, input bit r);
    arm = a; cap_valid = v; cap_pc = pc; cap_data = d; rd_en = r;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic idle_cycle();  applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); endtask
  task automatic do_arm();      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0); endtask
  task automatic do_read();     applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1); endtask
  task automatic cap(input logic [31:0] pc, input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, pc, d, 1'b0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; idle_cycle(); rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] pc_ctr;
    bit a, v, r;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_len[k] = 0; m_left[k] = 0; m_rd_idx[k] = 0;
      m_rem[k] = 0; m_trig[k] = 1'b0; m_valid[k] = 1'b0; m_data[k] = '0;
    end
    rst_n = 1'b0; trig_mode = 2'd0; trig_value = 32'd0;
    arm = 1'b0; cap_valid = 1'b0; cap_pc = '0; cap_data = '0; rd_en = 1'b0;

    do_reset();
    checkOutput("reset_state", 64'(bus8.state), 64'd0);
    checkOutput("reset_count", 64'(bus8.count), 64'd0);
    checkOutput("reset_rd_data", bus8.rd_data, 64'd0);

    // Immediate trigger, 8 post entries
    trig_mode = 2'd0; trig_value = 32'd0;
    do_arm();
    for (int i = 1; i <= 20; i++) begin
      cap(32'(4 * i), 32'(i));
      if (i == 8) checkOutput("t1_post_state", 64'(bus8.state), 64'd2);
      if (i == 9) checkOutput("t1_done_state", 64'(bus8.state), 64'd3);
    end
    checkOutput("t1_count", 64'(bus8.count), 64'd9);
    for (int i = 1; i <= 9; i++) begin
      do_read();
      checkOutput("t1_rd_valid", 64'(bus8.rd_valid), 64'd1);
      checkOutput("t1_rd_data", bus8.rd_data, {32'(4 * i), 32'(i)});
    end

    // PC match with buffer wrap
    trig_mode = 2'd1; trig_value = 32'h40;
    do_arm();
    for (int i = 0; i <= 30; i++) begin
      cap(32'(4 * i), 32'(4 * i));
      if (i == 16) checkOutput("t2_trig", 64'(bus8.triggered), 64'd1);
      if (i == 24) checkOutput("t2_done_state", 64'(bus8.state), 64'd3);
    end
    checkOutput("t2_count", 64'(bus8.count), 64'd16);
    for (int j = 0; j < 16; j++) begin
      do_read();
      checkOutput("t2_rd_data", bus8.rd_data, {32'(32'h24 + 4 * j), 32'(32'h24 + 4 * j)});
    end

    // Data match with no post entries (second instance)
    trig_mode = 2'd2; trig_value = 32'd5;
    do_arm();
    for (int i = 1; i <= 10; i++) begin
      cap(32'(4 * i), 32'(i));
      if (i == 5) checkOutput("t3_done_state", 64'(bus0.state), 64'd3);
    end
    checkOutput("t3_count", 64'(bus0.count), 64'd5);
    for (int i = 1; i <= 6; i++) begin
      do_read();
      if (i <= 5) checkOutput("t3_rd_data", bus0.rd_data, {32'(4 * i), 32'(i)});
      else        checkOutput("t3_rd_valid_empty", 64'(bus0.rd_valid), 64'd0);
    end

    // Never trigger
    trig_mode = 2'd3;
    do_arm();
    for (int i = 0; i < 40; i++) cap($urandom, $urandom);
    checkOutput("t4_state", 64'(bus8.state), 64'd1);
    checkOutput("t4_count", 64'(bus8.count), 64'd16);
    checkOutput("t4_triggered", 64'(bus8.triggered), 64'd0);
    do_arm();
    checkOutput("t4_rearm_count", 64'(bus8.count), 64'd0);

    // arm colliding with a capture, then re-arm during POST
    trig_mode = 2'd0;
    applyStimulus(1'b1, 1'b1, 32'h100, 32'hdead, 1'b0);
    for (int i = 1; i <= 9; i++) cap(32'(32'h100 + 4 * i), 32'(i));
    do_read();
    checkOutput("t5_first_entry", bus8.rd_data, {32'h104, 32'h1});
    do_arm();
    for (int i = 0; i < 3; i++) cap(32'(4 * i), 32'(i));
    checkOutput("t5_post_state", 64'(bus8.state), 64'd2);
    do_arm();
    checkOutput("t5_rearm_state", 64'(bus8.state), 64'd1);
    checkOutput("t5_rearm_trig", 64'(bus8.triggered), 64'd0);
    checkOutput("t5_rearm_count", 64'(bus8.count), 64'd0);

    // Reset in the middle of readout
    for (int i = 0; i < 12; i++) cap(32'(4 * i), 32'(i + 50));
    for (int i = 0; i < 3; i++) do_read();
    do_reset();
    checkOutput("t6_state", 64'(bus8.state), 64'd0);
    checkOutput("t6_count", 64'(bus8.count), 64'd0);
    checkOutput("t6_rd_valid", 64'(bus8.rd_valid), 64'd0);
    checkOutput("t6_rd_data", bus8.rd_data, 64'd0);
    do_read();
    checkOutput("t6_rd_ignored", 64'(bus8.rd_valid), 64'd0);

    // Randomized rounds against the model
    pc_ctr = 32'd0;
    for (int round = 0; round < 25; round++) begin
      trig_mode  = 2'($urandom_range(0, 3));
      trig_value = (trig_mode == 2'd1) ? 32'(4 * $urandom_range(0, 40)) : 32'($urandom_range(0, 15));
      do_arm();
      for (int c = 0; c < 60; c++) begin
        a = ($urandom_range(0, 99) < 3);
        v = ($urandom_range(0, 99) < 70);
        r = ($urandom_range(0, 99) < 50);
        rst_n = ($urandom_range(0, 199) != 0);
        applyStimulus(a, v, pc_ctr, 32'($urandom_range(0, 15)), r);
        if (v) pc_ctr = pc_ctr + 32'd4;
        if (pc_ctr > 32'd160) pc_ctr = 32'd0;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) do_read();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
- Parametrised commit-trace capture block for the RISC-V core.
- Records one entry (PC, result) per retired instruction into a circular buffer, with a selectable trigger and a post-trigger capture count.
- Once frozen, the buffer is read out oldest-first through a registered read port.
- Replaces ad-hoc single-value `test` observation with a windowed trace usable in simulation and on silicon.

Parameters:
- DATA_WIDTH, 32, width of captured result word.
- DEPTH, 16, buffer entries; power of 2, at least 2.
- POST_TRIG, 8, entries captured after the trigger entry; 0 to DEPTH-1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-low reset.
- cap_valid  in  1  retire strobe; an entry is presented this cycle.
- cap_pc  in  32  PC of the retired instruction.
- cap_data  in  DATA_WIDTH  result value (for example the `test` signal).
- arm  in  1  single-cycle pulse that starts a new capture.
- trig_mode  in  2  trigger condition: 00 immediate, 01 PC match, 10 data match, 11 never.
- trig_value  in  32  compare value; low DATA_WIDTH bits are used for data match.
- rd_en  in  1  pop the oldest entry (honoured only in DONE).
- rd_data  out  32+DATA_WIDTH  {pc, data} of the popped entry.
- rd_valid  out  1  rd_data is valid this cycle.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- triggered  out  1  set when the trigger fires; cleared by arm.

Behaviour:
- Reset: all of the following apply in the same cycle.
  - state=IDLE; rd_data=0; rd_valid=0; count=0; triggered=0.
  - Write and read pointers = 0; post counter = 0.
  - Memory array is not reset.
  - Reset mid-capture or mid-readout aborts immediately.
- arm: from any state, the next cycle is ARMED.
  - Clears the write pointer, count, triggered and the post counter.
  - arm takes priority over a same-cycle cap_valid; that entry is discarded.
- ARMED:
  - Each cap_valid writes {cap_pc, cap_data} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - count increments and saturates at DEPTH; older entries are overwritten.
  - Trigger is evaluated combinationally on the presented entry.
    - 00 fires on the first cap_valid.
    - 01 fires when cap_pc==trig_value.
    - 10 fires when cap_data==trig_value[DATA_WIDTH-1:0].
    - 11 never fires.
  - The trigger entry itself is written.
  - On fire: triggered=1, post counter=POST_TRIG, next state is POST; if POST_TRIG==0, next state is DONE.
- POST:
  - Each cap_valid writes as in ARMED and decrements the post counter.
  - The write that brings the counter to 0 is the final one; next state is DONE.
  - Further triggers are ignored.
- DONE:
  - Capture is frozen; cap_valid is ignored.
  - On entry, rd_ptr = wr_ptr - count (mod DEPTH), i.e. the oldest entry.
  - rd_en with count>0: rd_data = mem[rd_ptr] and rd_valid=1 on the next cycle (1-cycle latency); rd_ptr increments; count decrements.
  - rd_en with count==0: ignored; rd_valid=0.
  - rd_valid is a single-cycle pulse per accepted read; rd_data holds its value otherwise.
- IDLE: cap_valid and rd_en are ignored.
- Simultaneous trigger and wrap: both apply in the same cycle; count stays saturated.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package (riscv_dbg_pkg):
  - State encoding constants.
  - trig_mode encodings.
  - Entry width function (32+DATA_WIDTH).
- One sub-module, trace_ram: a DEPTH x (32+DATA_WIDTH) synchronous-write, synchronous-read array with no reset.
- FSM, pointers and counters live in the top module.

Test Plan:
- Immediate trigger, POST_TRIG=8: arm, then 20 captures with data=1..20, pc=4*data.
  - Required: DONE after data=9; count=9.
  - Readout returns data 1..9, pc 4..36, each with rd_valid one cycle after rd_en.
- PC match, wrap: trig_value=0x40; captures pc=0x00,0x04,..., data=pc.
  - Required: trigger at 0x40; DONE after 0x60; count=16.
  - Readout returns 0x24..0x60 in order.
- Data match with POST_TRIG=0: trig_value=5; data 1..10.
  - Required: DONE in the cycle after data=5; count=5.
  - Readout returns 1..5; a 6th rd_en gives rd_valid=0.
- Never mode: trig_mode=11; 40 captures.
  - Required: stays ARMED; count=16; triggered=0.
  - A fresh arm restarts with count=0.
- arm collision and re-arm: arm and cap_valid in the same cycle.
  - Required: that entry is absent.
  - arm during POST restarts to ARMED with triggered=0 and count=0.
- Reset mid-readout: RST low for one clock after 3 reads.
  - Required: state=IDLE, count=0, rd_valid=0, rd_data=0 on the next edge.
  - rd_en is then ignored.
